// File: rtl/btn_pkg.sv
// Shared defaults and types for the button event queue.
package btn_pkg;

  localparam int N_BTN_DEFAULT        = 4;
  localparam int MERGE_WINDOW_DEFAULT = 8;
  localparam int EVQ_DEPTH_DEFAULT    = 8;

  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_HOLDOFF = 1'b1
  } ch_state_t;

  typedef logic [$clog2(N_BTN_DEFAULT)-1:0] ev_id_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous first-word fall-through FIFO; data_out shows the head whenever !empty.
// A push while full is taken only when a pop happens in the same cycle.
module event_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers are exactly AW bits wide, so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_queue.sv
// Collapses debouncer pulse bursts into one event per press, arbitrates channels
// lowest-index first and queues event ids in a FWFT FIFO with a valid/ready handshake.
module btn_event_queue
  import btn_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEFAULT,
  parameter int MERGE_WINDOW = MERGE_WINDOW_DEFAULT,
  parameter int DEPTH        = EVQ_DEPTH_DEFAULT,
  localparam int ID_W   = (N_BTN > 1) ? $clog2(N_BTN) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int HOLD_W = $clog2(MERGE_WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_pulse,
  output logic             ev_valid,
  output logic [ID_W-1:0]  ev_id,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] ev_count,
  output logic             overflow,
  input  logic             clr_overflow
);

  logic [N_BTN-1:0]  prev;
  logic [N_BTN-1:0]  rise;
  logic [N_BTN-1:0]  accept;
  logic [N_BTN-1:0]  drop;
  logic [N_BTN-1:0]  pending;
  logic [N_BTN-1:0]  grant;
  logic [ID_W-1:0]   wr_id;
  logic              found;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  ch_state_t         ch_state [N_BTN];
  logic [HOLD_W-1:0] hold_cnt [N_BTN];

  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;
  assign push     = (|pending) && (!fifo_full || pop);

  always_comb begin
    rise   = btn_pulse & ~prev;
    accept = '0;
    grant  = '0;
    wr_id  = '0;
    found  = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      // A holdoff counter sitting at zero is on its last cycle, so a rise there
      // lands exactly MERGE_WINDOW edges after the previous accept and counts.
      accept[i] = rise[i] && ((ch_state[i] == CH_IDLE) || (hold_cnt[i] == '0));
      if (pending[i] && !found) begin
        grant[i] = 1'b1;
        wr_id    = ID_W'(i);
        found    = 1'b1;
      end
    end
    drop = accept & pending;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        ch_state[i] <= CH_IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      prev <= btn_pulse;
      for (int i = 0; i < N_BTN; i++) begin
        if (accept[i]) begin
          ch_state[i] <= CH_HOLDOFF;
          hold_cnt[i] <= HOLD_W'(MERGE_WINDOW - 1);
        end else if (ch_state[i] == CH_HOLDOFF) begin
          if (hold_cnt[i] == '0) begin
            ch_state[i] <= CH_IDLE;
          end else begin
            hold_cnt[i] <= hold_cnt[i] - HOLD_W'(1);
          end
        end
      end
      pending <= (pending & ~(push ? grant : '0)) | (accept & ~pending);
      // A drop in the same cycle as a clear must stay visible.
      if (|drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  event_fifo #(
    .WIDTH(ID_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .data_in (wr_id),
    .full    (fifo_full),
    .pop     (pop),
    .data_out(ev_id),
    .empty   (fifo_empty),
    .count   (ev_count)
  );

endmodule

// File: tb/tb_btn_event_queue.sv
// Self-checking bench for btn_event_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_btn_event_queue;

  localparam int N  = 4;
  localparam int MW = 8;
  localparam int D  = 8;

  logic       clk;
  logic       rst;
  logic [3:0] btn_pulse;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic       ev_ready;
  logic [3:0] ev_count;
  logic       overflow;
  logic       clr_overflow;

  int n_tests;
  int n_fail;

  // Reference model state
  int m_last [N];
  bit m_prev [N];
  bit m_pend [N];
  int m_q [$];
  bit m_ovf;
  int m_edge;

  btn_event_queue #(
    .N_BTN(N),
    .MERGE_WINDOW(MW),
    .DEPTH(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_pulse   (btn_pulse),
    .ev_valid    (ev_valid),
    .ev_id       (ev_id),
    .ev_ready    (ev_ready),
    .ev_count    (ev_count),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_last[i] = -1000;
      m_prev[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently applied, then clock the DUT.
  task automatic tick();
    bit pop;
    bit wr;
    bit any_drop;
    int cand;
    bit acc [N];
    bit pre [N];
    pop  = (m_q.size() > 0) && ev_ready;
    cand = -1;
    for (int i = 0; i < N; i++) if (m_pend[i] && cand < 0) cand = i;
    wr = (cand >= 0) && ((m_q.size() < D) || pop);
    any_drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      pre[i] = m_pend[i];
      acc[i] = btn_pulse[i] && !m_prev[i] && ((m_edge - m_last[i]) >= MW);
      if (acc[i]) m_last[i] = m_edge;
      if (acc[i] && pre[i]) any_drop = 1'b1;
    end
    if (pop) void'(m_q.pop_front());
    if (wr) begin
      m_q.push_back(cand);
      m_pend[cand] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i] && !pre[i]) m_pend[i] = 1'b1;
      m_prev[i] = btn_pulse[i];
    end
    if (any_drop) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
    m_edge++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    btn_pulse = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int k;
    btn_pulse = '0;
    ev_ready  = 1'b1;
    k = 0;
    while ((ev_valid || m_q.size() > 0) && k < 30) begin
      tick();
      k++;
    end
    ev_ready = 1'b0;
    n_tests++;
    if (ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_timeout: ev_valid=%0b count=%0d, required empty within 30 cycles", ev_valid, ev_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_pulse = '0;
    ev_ready = 1'b0;
    clr_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", ev_valid); end
    n_tests++;
    if (ev_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", ev_count); end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single_burst();
    ev_ready = 1'b0;
    btn_pulse = 4'b0100; tick();
    n_tests++;
    if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL burst_no_bypass: ev_valid=%0b want 0", ev_valid); end
    btn_pulse = 4'b0000; tick();
    n_tests++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd2 || ev_count !== 4'd1) begin
      n_fail++;
      $display("FAIL burst_first: valid=%0b id=%0d count=%0d want 1/2/1", ev_valid, ev_id, ev_count);
    end
    btn_pulse = 4'b0100; tick();
    btn_pulse = 4'b0000; tick();
    btn_pulse = 4'b0100; tick();
    idle(20);
    n_tests++;
    if (ev_count !== 4'd1 || ev_id !== 2'd2) begin
      n_fail++;
      $display("FAIL burst_collapse: count=%0d id=%0d want 1/2", ev_count, ev_id);
    end
    drain();
  endtask

  task automatic test_repress();
    ev_ready = 1'b0;
    btn_pulse = 4'b0010; tick();
    idle(7);
    btn_pulse = 4'b0010; tick();
    idle(3);
    n_tests++;
    if (ev_count !== 4'd2) begin n_fail++; $display("FAIL repress_8: count=%0d want 2", ev_count); end
    drain();
    idle(10);
    btn_pulse = 4'b0010; tick();
    idle(6);
    btn_pulse = 4'b0010; tick();
    idle(3);
    n_tests++;
    if (ev_count !== 4'd1) begin n_fail++; $display("FAIL repress_7: count=%0d want 1", ev_count); end
    drain();
    idle(10);
  endtask

  task automatic test_simultaneous();
    ev_ready = 1'b1;
    btn_pulse = 4'b1001; tick();
    btn_pulse = 4'b0000; tick();
    n_tests++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd0) begin
      n_fail++; $display("FAIL simul_first: valid=%0b id=%0d want 1/0", ev_valid, ev_id);
    end
    tick();
    n_tests++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd3) begin
      n_fail++; $display("FAIL simul_second: valid=%0b id=%0d want 1/3", ev_valid, ev_id);
    end
    tick();
    n_tests++;
    if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL simul_empty: valid=%0b want 0", ev_valid); end
    ev_ready = 1'b0;
    idle(10);
  endtask

  task automatic test_full();
    ev_ready = 1'b0;
    for (int e = 0; e <= 25; e++) begin
      btn_pulse = (e == 0 || e == 8) ? 4'b1111 : (e == 16 || e == 24) ? 4'b0001 : 4'b0000;
      tick();
      if (e == 16) begin
        n_tests++;
        if (ev_count !== 4'd8) begin n_fail++; $display("FAIL full_count: count=%0d want 8", ev_count); end
      end
      if (e == 20) begin
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pending_no_ovf: overflow=%0b want 0", overflow); end
      end
      if (e == 24) begin
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_drop_ovf: overflow=%0b want 1", overflow); end
      end
    end
    btn_pulse = '0;
    ev_ready = 1'b1; tick();
    ev_ready = 1'b0;
    n_tests++;
    if (ev_count !== 4'd8 || ev_id !== 2'd1) begin
      n_fail++; $display("FAIL full_pop_push: count=%0d id=%0d want 8/1", ev_count, ev_id);
    end
  endtask

  task automatic test_overflow_race();
    ev_ready = 1'b0;
    for (int e = 0; e <= 17; e++) begin
      btn_pulse    = (e == 8 || e == 16) ? 4'b0001 : 4'b0000;
      clr_overflow = (e == 2 || e == 16 || e == 17);
      tick();
      if (e == 2) begin
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_pre: overflow=%0b want 0", overflow); end
      end
      if (e == 16) begin
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_race_set_wins: overflow=%0b want 1", overflow); end
      end
      if (e == 17) begin
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: overflow=%0b want 0", overflow); end
      end
    end
    clr_overflow = 1'b0;
    drain();
    idle(10);
  endtask

  task automatic test_reset_mid();
    ev_ready = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      btn_pulse = (e == 0) ? 4'b1011 : (e == 8) ? 4'b1100 : 4'b0000;
      tick();
    end
    n_tests++;
    if (ev_count !== 4'd5) begin n_fail++; $display("FAIL mid_prefill: count=%0d want 5", ev_count); end
    rst = 1'b1;
    #2;
    n_tests++;
    if (ev_valid !== 1'b0 || ev_count !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset_async: valid=%0b count=%0d want 0/0", ev_valid, ev_count);
    end
    #1;
    rst = 1'b0;
    model_reset();
    btn_pulse = 4'b0100; tick();
    btn_pulse = 4'b0000; tick();
    n_tests++;
    if (ev_valid !== 1'b1 || ev_id !== 2'd2 || ev_count !== 4'd1) begin
      n_fail++; $display("FAIL mid_after_reset: valid=%0b id=%0d count=%0d want 1/2/1", ev_valid, ev_id, ev_count);
    end
    drain();
    idle(10);
  endtask

  task automatic test_random();
    logic [1:0] exp_id;
    int bad;
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) btn_pulse[i] = ($urandom_range(0, 5) == 0);
      ev_ready     = (c < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      tick();
      n_tests++;
      exp_id = (m_q.size() > 0) ? m_q[0][1:0] : 2'd0;
      if (ev_valid !== (m_q.size() > 0) || ev_count !== 4'(m_q.size()) || overflow !== m_ovf ||
          (m_q.size() > 0 && ev_id !== exp_id)) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random_c%0d: valid=%0b count=%0d id=%0d ovf=%0b want %0b/%0d/%0d/%0b",
                   c, ev_valid, ev_count, ev_id, overflow, (m_q.size() > 0), m_q.size(), exp_id, m_ovf);
        bad++;
      end
    end
    clr_overflow = 1'b0;
    drain();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_edge  = 0;
    rst = 1'b1;
    btn_pulse = '0;
    ev_ready = 1'b0;
    clr_overflow = 1'b0;
    test_reset();
    test_single_burst();
    test_repress();
    test_simultaneous();
    test_full();
    test_overflow_race();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_event_queue.md
Name: btn_event_queue

Overview:
- Sits directly downstream of the per-button debouncers. Takes their short pulse bursts, which are several one-cycle highs per press.
- Collapses each burst into exactly one press event and arbitrates simultaneous presses across buttons.
- Queues events in a small FIFO with a valid/ready handshake toward the game/control logic.

Parameters:
- N_BTN, 4, number of debounced button channels.
- MERGE_WINDOW, 8, cycles after an accepted event during which further rises on that channel are ignored (must be >= 2).
- DEPTH, 8, FIFO entries (power of two).
- ID_W, $clog2(N_BTN), width of event id (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_pulse  in  N_BTN  debouncer outputs, one bit per button, synchronous to clk.
- ev_valid  out  1  head-of-queue event present.
- ev_id  out  ID_W  button index of head event.
- ev_ready  in  1  consumer accepts head event; a pop occurs when ev_valid && ev_ready.
- ev_count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky: an event was dropped.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - Registered outputs: ev_valid=0, ev_count=0, overflow=0.
  - ev_id is driven from FIFO storage and is don't-care while ev_valid=0.
  - Internal state: prev=0, channels IDLE, pending=0, FIFO pointers=0.
  - Reset mid-operation discards all queued and pending events immediately.
- Rise detect: per channel, rise[i] = btn_pulse[i] & ~prev[i]; prev is updated every cycle.
- Per-channel FSM, IDLE / HOLDOFF:
  - IDLE with rise at edge k: the event is accepted. Go to HOLDOFF and load the counter with MERGE_WINDOW-1.
  - HOLDOFF: rises are ignored. The counter decrements each cycle; at 0 the channel returns to IDLE on the next edge.
  - A rise exactly MERGE_WINDOW cycles after acceptance is accepted again.
- Pending flags:
  - An accepted event sets pending[i] at edge k.
  - If pending[i] is already set, the new event is dropped and overflow is set.
- Arbiter:
  - Each cycle, the lowest-index set pending bit is the write candidate.
  - The write happens when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - On write, that pending bit clears. One write per cycle maximum.
- Latency:
  - A pulse sampled at edge k, with no contention, is written at edge k+1.
  - ev_valid rises after edge k+1.
  - There is no empty-FIFO bypass.
- FIFO:
  - First-word fall-through; ev_id is valid whenever ev_valid=1.
  - Pointers wrap modulo DEPTH.
  - ev_count = writes - pops: +1 on write only, -1 on pop only, unchanged on both.
  - Pop when empty is impossible because ev_valid=0.
  - ev_id/ev_valid must hold stable while ev_valid && !ev_ready.
- Overflow:
  - Set on any drop.
  - clr_overflow clears it. If clr_overflow and a drop occur in the same cycle, set wins.
- Simultaneous events: multiple channels accepted in the same cycle are all pended and written in ascending index order over successive cycles.

Decomposition:
- Package btn_pkg holds:
  - N_BTN_DEFAULT, MERGE_WINDOW_DEFAULT, EVQ_DEPTH_DEFAULT.
  - Channel state encoding (CH_IDLE, CH_HOLDOFF).
  - ev_id_t typedef.
- One sub-module, event_fifo: a synchronous FWFT FIFO with parameters WIDTH and DEPTH, and ports push/data_in/full/pop/data_out/empty/count.
- Rise detection, channel FSMs and the arbiter stay in btn_event_queue.

Test Plan:
- Single burst: ch2 driven 1,0,1,0,1 starting at edge 10, ev_ready=0.
  - Exactly one event, id=2; ev_valid=1 after edge 11; ev_count=1.
  - After a further 20 idle cycles, still count=1.
- Re-press spacing: ch1 rises at edges 10 and 18 -> two events. Rises at edges 10 and 17 -> one event (MERGE_WINDOW=8).
- Simultaneous presses: ch3 and ch0 rise at the same edge, ev_ready=1 -> ev_id=0 is popped first, then ev_id=3 one cycle later.
- Full FIFO handling, with ev_ready=0:
  - Produce 8 events -> ev_count=8.
  - A 9th event on ch0 stays pending, overflow=0.
  - A second ch0 event after holdoff -> overflow=1.
  - Raise ev_ready for one cycle -> the pending event is written in the same cycle as the pop; ev_count stays 8.
- Overflow clear race: assert clr_overflow on the cycle of a new drop -> overflow stays 1. clr_overflow alone -> overflow=0.
- Reset mid-operation: with 5 queued and ch2 in HOLDOFF, pulse rst between edges -> ev_valid=0 and ev_count=0 immediately. A ch2 rise on the first edge after reset is accepted.
